// File: rtl/poly_oscillator_bank.sv
// poly_oscillator_bank: time-multiplexed bank of VOICES phase-accumulator
// oscillators. A sample_tick starts a frame that walks every voice, one per
// cycle, emitting per-voice samples, then presents the signed mix of the frame.
// Optional build macro: OSC_PULSE_WIDTH_EN adds a per-voice pulse width input
// and turns mode 3 into a PULSE waveform (otherwise mode 3 is silent).
module poly_oscillator_bank #(
  parameter int VOICES      = 8,
  parameter int AUDIO_WIDTH = 24,
  parameter int PHASE_WIDTH = 32,
  localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1,
  localparam int AW = AUDIO_WIDTH,
  localparam int PW = PHASE_WIDTH,
  localparam int MW = AUDIO_WIDTH + $clog2(VOICES)
) (
  input  logic          clock,
  input  logic          reset_l,
  input  logic          sample_tick,
  input  logic          cfg_we,
  input  logic [VW-1:0] cfg_voice,
  input  logic [PW-1:0] cfg_increment,
  input  logic [1:0]    cfg_mode,
`ifdef OSC_PULSE_WIDTH_EN
  input  logic [PW-1:0] cfg_pulse_width,
`endif
  input  logic          cfg_enable,
  output logic          busy,
  output logic          overrun,
  output logic          voice_valid,
  output logic [VW-1:0] voice_index,
  output logic [AW-1:0] voice_sample,
  output logic          mix_valid,
  output logic [MW-1:0] mix
);

  localparam logic [AW-1:0] MAX_S    = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] MIN_S    = {1'b1, {(AW-1){1'b0}}};
  localparam logic [VW-1:0] LAST_IDX = VW'(VOICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_MIX  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [VW-1:0] idx_q, idx_d;

  // Per-voice configuration and phase
  logic [PW-1:0]     phase_q [VOICES];
  logic [PW-1:0]     inc_q   [VOICES];
  logic [1:0]        mode_q  [VOICES];
  logic [VOICES-1:0] en_q;
`ifdef OSC_PULSE_WIDTH_EN
  logic [PW-1:0]     width_q [VOICES];
`endif

  // Output / datapath registers
  logic          busy_q, busy_d;
  logic          ovr_pend_q, ovr_pend_d;
  logic          overrun_q, overrun_d;
  logic          vvalid_q, vvalid_d;
  logic [VW-1:0] vindex_q, vindex_d;
  logic [AW-1:0] vsample_q, vsample_d;
  logic          mvalid_q, mvalid_d;
  logic [MW-1:0] mix_q, mix_d;
  logic [MW-1:0] acc_q, acc_d;

  logic [AW-1:0] cur_sample_s;
  logic          adv_s;

  // SAW / SQUARE / TRIANGLE from the top phase bits; offset removal is an MSB flip.
  function automatic logic [AW-1:0] wave_sample(input logic [AW-1:0] top,
                                                input logic [AW-1:0] u,
                                                input logic [1:0]    mode);
    logic [AW-1:0] t;
    t = top[AW-1] ? ~u : u;
    case (mode)
      2'd0:    wave_sample = top ^ MIN_S;
      2'd1:    wave_sample = top[AW-1] ? MIN_S : MAX_S;
      2'd2:    wave_sample = t ^ MIN_S;
      default: wave_sample = '0;
    endcase
  endfunction

  // State and frame-position register
  always_ff @(posedge clock) begin
    if (!reset_l) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: IDLE -> RUN (one voice per cycle) -> MIX -> IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
          idx_d   = idx_q;
        end
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_MIX;
          idx_d   = '0;
        end else begin
          state_d = ST_RUN;
          idx_d   = idx_q + VW'(1);
        end
      end
      ST_MIX: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Sample of the voice currently addressed, from its phase before the update
  always_comb begin
    cur_sample_s = '0;
    if (en_q[idx_q]) begin
      cur_sample_s = wave_sample(phase_q[idx_q][PW-1 -: AW],
                                 phase_q[idx_q][PW-2 -: AW],
                                 mode_q[idx_q]);
`ifdef OSC_PULSE_WIDTH_EN
      if (mode_q[idx_q] == 2'd3) begin
        cur_sample_s = (phase_q[idx_q] < width_q[idx_q]) ? MAX_S : MIN_S;
      end else begin
        cur_sample_s = cur_sample_s;
      end
`endif
    end else begin
      cur_sample_s = '0;
    end
  end

  assign adv_s = (state_q == ST_RUN) && en_q[idx_q];

  // Output next-state: voice stream, mix accumulation, busy and overrun flags
  always_comb begin
    busy_d     = (state_q != ST_IDLE);
    ovr_pend_d = sample_tick && (state_q != ST_IDLE);
    overrun_d  = ovr_pend_q;
    vvalid_d   = 1'b0;
    vindex_d   = vindex_q;
    vsample_d  = vsample_q;
    mvalid_d   = 1'b0;
    mix_d      = mix_q;
    acc_d      = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          acc_d = '0;
        end else begin
          acc_d = acc_q;
        end
      end
      ST_RUN: begin
        vvalid_d  = 1'b1;
        vindex_d  = idx_q;
        vsample_d = cur_sample_s;
        acc_d     = acc_q + MW'($signed(cur_sample_s));
      end
      ST_MIX: begin
        mvalid_d = 1'b1;
        mix_d    = acc_q;
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clock) begin
    if (!reset_l) begin
      busy_q     <= 1'b0;
      ovr_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
      vvalid_q   <= 1'b0;
      vindex_q   <= '0;
      vsample_q  <= '0;
      mvalid_q   <= 1'b0;
      mix_q      <= '0;
      acc_q      <= '0;
    end else begin
      busy_q     <= busy_d;
      ovr_pend_q <= ovr_pend_d;
      overrun_q  <= overrun_d;
      vvalid_q   <= vvalid_d;
      vindex_q   <= vindex_d;
      vsample_q  <= vsample_d;
      mvalid_q   <= mvalid_d;
      mix_q      <= mix_d;
      acc_q      <= acc_d;
    end
  end

  // Voice registers: advance the processed voice, then apply config writes.
  // A write lands after the advance so an enable rising edge clears the phase.
  always_ff @(posedge clock) begin
    if (!reset_l) begin
      for (int v = 0; v < VOICES; v++) begin
        phase_q[v] <= '0;
        inc_q[v]   <= '0;
        mode_q[v]  <= 2'd0;
`ifdef OSC_PULSE_WIDTH_EN
        width_q[v] <= {1'b1, {(PW-1){1'b0}}};
`endif
      end
      en_q <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        if (adv_s && (idx_q == VW'(v))) begin
          phase_q[v] <= phase_q[v] + inc_q[v];
        end
        if (cfg_we && (cfg_voice == VW'(v))) begin
          inc_q[v]  <= cfg_increment;
          mode_q[v] <= cfg_mode;
          en_q[v]   <= cfg_enable;
`ifdef OSC_PULSE_WIDTH_EN
          width_q[v] <= cfg_pulse_width;
`endif
          if (cfg_enable && !en_q[v]) begin
            phase_q[v] <= '0;
          end
        end
      end
    end
  end

  assign busy         = busy_q;
  assign overrun      = overrun_q;
  assign voice_valid  = vvalid_q;
  assign voice_index  = vindex_q;
  assign voice_sample = vsample_q;
  assign mix_valid    = mvalid_q;
  assign mix          = mix_q;

endmodule
